e_muldiv_unit: RTL and testbench
================================

Name: e_muldiv_unit

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core; consumes the E-stage operands and decoded op that the D/E pipeline register delivers.
- Holds architectural HI/LO; models fixed multi-cycle latency with a busy countdown.
- Drives busy back to the hazard logic so that D-stage mult/div/mfhi/mflo/mthi/mtlo stall.
- E-stage mfhi/mflo read the hi/lo outputs directly.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage holds a valid mult/div-class instruction this cycle.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; all other codes behave as NONE.
- cancel  input  1  exception/interrupt flush; blocks the current start.
- rs_val  input  32  E-stage forwarded rs value.
- rt_val  input  32  E-stage forwarded rt value.
- busy  output  1  operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset: busy=0, hi=0, lo=0, internal counter=0, pending result=0.
- Reset mid-operation aborts the operation; no commit occurs.
- Accept condition: start && !cancel && !busy at a posedge.
  - start while busy is ignored entirely; the hazard unit guarantees this cannot happen, and the bench checks no state change.
  - cancel=1 suppresses start for every op, including MTHI/MTLO.
- MTHI/MTLO on accept: hi (or lo) <= rs_val at that edge, visible next cycle; busy stays 0.
- MULT/MULTU on accept:
  - Pending {HI,LO} <= 64-bit product of rs_val and rt_val (signed or unsigned).
  - Counter <= MULT_CYCLES; busy=1 on the following cycle.
- DIV/DIVU on accept:
  - Pending LO <= quotient, HI <= remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Counter <= DIV_CYCLES.
  - Divisor == 0: operation still runs for the full DIV_CYCLES, but the commit leaves hi/lo unchanged.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Countdown: while the counter is nonzero, it decrements each cycle; busy = (counter != 0).
  - At the edge where the counter goes 1 -> 0, the pending result is written to hi/lo.
  - Result is visible in the same cycle busy first reads 0.
  - Total: busy high for exactly N cycles after the accept edge.
- cancel while busy does not abort; an in-flight operation always completes (MIPS semantics).
- Back-to-back: a new start is accepted in the first cycle busy reads 0.
- hi/lo change only on an MTHI/MTLO accept or a commit edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 7 MADD / op 8 MADDU accumulate {hi,lo} + product into {hi,lo}.
  - Product is signed for MADD, unsigned for MADDU; the 64-bit sum wraps.
  - The accumulate base is hi/lo sampled at the accept edge.
  - Latency is MULT_CYCLES.
- Undefined: ops 7/8 behave as NONE; no busy, no state change.

Test Plan:
- Reset then idle: busy=0, hi=0, lo=0; an op=NONE start leaves all outputs unchanged.
- MULT rs=0xFFFFFFFD (-3), rt=5:
  - Accept at edge T0; busy=1 for cycles T0+1..T0+5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1 when busy drops; hi/lo unchanged before that.
- MULTU 0xFFFFFFFF*2: hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/0 with hi=0x11, lo=0x22: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Boundary events:
  - start+cancel with MULT: busy stays 0.
  - MTHI rs=0xABCD with cancel=0: hi=0xABCD next cycle.
  - MTLO issued while busy: ignored.
  - reset at busy cycle 3: busy=0, hi=lo=0 next cycle.
  - Under MDU_MADD_EN: MADD 2*3 onto hi=0, lo=0xFFFFFFFF gives hi=1, lo=5.

Source files
------------

// File: rtl/e_muldiv_unit_if.sv
// Execute-stage multiply/divide bus: operand/op delivery from the D/E register,
// busy back to the hazard logic, and architectural HI/LO to the E-stage readers.
interface e_muldiv_unit_if;
  logic        start;
  logic [3:0]  op;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, cancel, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, cancel, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/e_muldiv_unit.sv
// Execute-stage MIPS multiply/divide unit with architectural HI/LO.
// The result is computed at accept time and held pending; a countdown models
// the fixed multi-cycle latency and the result commits as the count hits zero.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module e_muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  e_muldiv_unit_if.slave mdu
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        busy;
  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] uq, ur, quo, rem;

  assign busy   = (cnt_q != 4'd0);
  assign accept = mdu.start && !mdu.cancel && !busy;

  // Operand arithmetic: products and sign-magnitude division
  always_comb begin
    // Sign-extended operands give the correct low 64 bits of the signed product
    prod_s     = {{32{mdu.rs_val[31]}}, mdu.rs_val} * {{32{mdu.rt_val[31]}}, mdu.rt_val};
    prod_u     = {32'd0, mdu.rs_val} * {32'd0, mdu.rt_val};
    div_signed = (mdu.op == OpDiv);
    a_mag      = (div_signed && mdu.rs_val[31]) ? (32'd0 - mdu.rs_val) : mdu.rs_val;
    b_mag      = (div_signed && mdu.rt_val[31]) ? (32'd0 - mdu.rt_val) : mdu.rt_val;
    // Zero divisor is substituted so the divider never sees it; commit is suppressed
    b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq         = a_mag / b_safe;
    ur         = a_mag % b_safe;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated wraps to itself
    quo        = (div_signed && (mdu.rs_val[31] ^ mdu.rt_val[31])) ? (32'd0 - uq) : uq;
    rem        = (div_signed && mdu.rs_val[31]) ? (32'd0 - ur) : ur;
  end

  // Next-state: countdown/commit while busy, otherwise accept a new op
  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && pend_wr_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (accept) begin
      case (mdu.op)
        OpMthi: hi_d = mdu.rs_val;
        OpMtlo: lo_d = mdu.rs_val;
        OpMult: begin
          pend_d    = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MultCnt;
        end
        OpMultu: begin
          pend_d    = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MultCnt;
        end
        OpDiv, OpDivu: begin
          pend_d    = {rem, quo};
          pend_wr_d = (mdu.rt_val != 32'd0);
          cnt_d     = DivCnt;
        end
`ifdef MDU_MADD_EN
        OpMadd: begin
          pend_d    = {hi_q, lo_q} + prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MultCnt;
        end
        OpMaddu: begin
          pend_d    = {hi_q, lo_q} + prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MultCnt;
        end
`endif
        default: ;
      endcase
    end
  end

  // State register with synchronous reset; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Outputs
  always_comb begin
    mdu.busy = busy;
    mdu.hi   = hi_q;
    mdu.lo   = lo_q;
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Bench for e_muldiv_unit: deadline-based model checked every cycle, plus
// directed vectors with hand-computed HI/LO values.
module tb_e_muldiv_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  e_muldiv_unit_if u_if ();

  e_muldiv_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: architectural HI/LO plus the edge index at which a pending result lands
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  bit          m_wr = 0;
  int          edge_k = 0;
  int          m_end = 0;

  always @(posedge clk) begin
    edge_k = edge_k + 1;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_end = 0; m_wr = 0;
    end else if (edge_k == m_end) begin
      if (m_wr) {m_hi, m_lo} = m_res;
    end else if (edge_k > m_end && u_if.start && !u_if.cancel) begin
      case (u_if.op)
        OpMthi: m_hi = u_if.rs_val;
        OpMtlo: m_lo = u_if.rs_val;
        OpMult: begin
          m_res = 64'(longint'($signed(u_if.rs_val)) * longint'($signed(u_if.rt_val)));
          m_wr = 1; m_end = edge_k + MultN;
        end
        OpMultu: begin
          m_res = {32'd0, u_if.rs_val} * {32'd0, u_if.rt_val};
          m_wr = 1; m_end = edge_k + MultN;
        end
        OpDiv: begin
          int sa, sb;
          sa = $signed(u_if.rs_val);
          sb = $signed(u_if.rt_val);
          m_wr = (sb != 0);
          if (sb == 0) m_res = '0;
          else if (sa == 32'sh8000_0000 && sb == -1) m_res = {32'd0, 32'h8000_0000};
          else m_res = {32'(sa % sb), 32'(sa / sb)};
          m_end = edge_k + DivN;
        end
        OpDivu: begin
          m_wr = (u_if.rt_val != 0);
          if (m_wr) m_res = {u_if.rs_val % u_if.rt_val, u_if.rs_val / u_if.rt_val};
          m_end = edge_k + DivN;
        end
`ifdef MDU_MADD_EN
        4'd7: begin
          m_res = {m_hi, m_lo} +
                  64'(longint'($signed(u_if.rs_val)) * longint'($signed(u_if.rt_val)));
          m_wr = 1; m_end = edge_k + MultN;
        end
        4'd8: begin
          m_res = {m_hi, m_lo} + {32'd0, u_if.rs_val} * {32'd0, u_if.rt_val};
          m_wr = 1; m_end = edge_k + MultN;
        end
`endif
        default: ;
      endcase
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checks = checks + 3;
      if (u_if.busy !== (edge_k < m_end)) begin
        errors = errors + 1;
        $display("FAIL cmp_busy t=%0t got=%b exp=%b", $time, u_if.busy, edge_k < m_end);
      end
      if (u_if.hi !== m_hi) begin
        errors = errors + 1;
        $display("FAIL cmp_hi t=%0t got=%h exp=%h", $time, u_if.hi, m_hi);
      end
      if (u_if.lo !== m_lo) begin
        errors = errors + 1;
        $display("FAIL cmp_lo t=%0t got=%h exp=%h", $time, u_if.lo, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one op for one edge; called and returning at a negedge
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    u_if.start  = 1'b1;
    u_if.op     = o;
    u_if.rs_val = a;
    u_if.rt_val = b;
    u_if.cancel = c;
    @(negedge clk);
    u_if.start  = 1'b0;
    u_if.op     = OpNone;
    u_if.cancel = 1'b0;
  endtask

  // Count remaining busy cycles, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (u_if.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1;
    u_if.start = 0; u_if.op = '0; u_if.cancel = 0; u_if.rs_val = '0; u_if.rt_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_hi", u_if.hi, 32'd0);
    chk("rst_lo", u_if.lo, 32'd0);

    issue(OpNone, 32'h1234, 32'h5678, 1'b0);
    chk("none_busy", {31'd0, u_if.busy}, 32'd0);
    chk("none_hi", u_if.hi, 32'd0);

    // MULT -3 * 5
    issue(OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult_hi_hold", u_if.hi, 32'd0);
    wait_idle(n);
    chk("mult_len", n, 32'd5);
    chk("mult_hi", u_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", u_if.lo, 32'hFFFF_FFF1);

    // Back-to-back: accepted in the first idle cycle
    issue(OpMultu, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("b2b_busy", {31'd0, u_if.busy}, 32'd1);
    wait_idle(n);
    chk("multu_hi", u_if.hi, 32'h0000_0001);
    chk("multu_lo", u_if.lo, 32'hFFFF_FFFE);

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_len", n, 32'd10);
    chk("div_lo", u_if.lo, 32'hFFFF_FFFD);
    chk("div_hi", u_if.hi, 32'hFFFF_FFFF);

    issue(OpMthi, 32'h11, 32'd0, 1'b0);
    issue(OpMtlo, 32'h22, 32'd0, 1'b0);
    issue(OpDivu, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    chk("div0_len", n, 32'd10);
    chk("div0_hi", u_if.hi, 32'h11);
    chk("div0_lo", u_if.lo, 32'h22);

    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    chk("divmin_lo", u_if.lo, 32'h8000_0000);
    chk("divmin_hi", u_if.hi, 32'h0);

    // start + cancel is blocked, including MTHI
    issue(OpMult, 32'd7, 32'd7, 1'b1);
    chk("cancel_busy", {31'd0, u_if.busy}, 32'd0);
    issue(OpMthi, 32'h9999, 32'd0, 1'b1);
    chk("cancel_mthi", u_if.hi, 32'h0);

    issue(OpMthi, 32'hABCD, 32'd0, 1'b0);
    chk("mthi", u_if.hi, 32'hABCD);

    // MTLO while busy is ignored; cancel while busy does not abort
    issue(OpMult, 32'd2, 32'd3, 1'b0);
    issue(OpMtlo, 32'h5555, 32'd0, 1'b0);
    chk("mtlo_busy_lo", u_if.lo, 32'h8000_0000);
    issue(OpNone, 32'd0, 32'd0, 1'b1);
    wait_idle(n);
    chk("busy_rest_len", n, 32'd3);
    chk("mult6_lo", u_if.lo, 32'd6);
    chk("mult6_hi", u_if.hi, 32'd0);

    // Reset at busy cycle 3
    issue(OpMult, 32'd9, 32'd9, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rstmid_hi", u_if.hi, 32'd0);
    chk("rstmid_lo", u_if.lo, 32'd0);
    repeat (6) @(negedge clk);
    chk("rstmid_nocommit", u_if.lo, 32'd0);

    // MADD onto hi=0, lo=0xFFFFFFFF
    issue(OpMtlo, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(OpMadd, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    wait_idle(n);
    chk("madd_len", n, 32'd5);
    chk("madd_hi", u_if.hi, 32'd1);
    chk("madd_lo", u_if.lo, 32'd5);
`else
    chk("madd_off_busy", {31'd0, u_if.busy}, 32'd0);
    chk("madd_off_hi", u_if.hi, 32'd0);
    chk("madd_off_lo", u_if.lo, 32'hFFFF_FFFF);
`endif
    wait_idle(n);

    // Undefined op code behaves as NONE
    issue(4'd15, 32'd4, 32'd4, 1'b0);
    chk("op15_busy", {31'd0, u_if.busy}, 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
